// File: rtl/round_robin_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot grant, release on done or withdrawal,
// and a hold limit that revokes a grant after MAX_HOLD cycles.
module round_robin_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

    state_e     state_q,     state_d;
    logic [7:0] gnt_q,       gnt_d;
    logic [2:0] gnt_id_q,    gnt_id_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       timeout_q,   timeout_d;
    logic [7:0] hold_q,      hold_d;
    logic [2:0] last_id_q,   last_id_d;

    logic       pick_found;
    logic [2:0] pick_id;

    // Returns {found, index} of the first set request searching upward from last+1 with wrap.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        // Walk the search order backwards so the earliest candidate overwrites the rest.
        for (int i = 7; i >= 0; i--) begin
            idx = last + 3'(i) + 3'd1;
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign {pick_found, pick_id} = rr_pick(req, last_id_q);

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_d      = hold_q;
        last_id_d   = last_id_q;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = GRANT;
                    gnt_d       = 8'b0000_0001 << pick_id;
                    gnt_id_d    = pick_id;
                    gnt_valid_d = 1'b1;
                    hold_d      = 8'd0;
                    last_id_d   = pick_id;
                end
            end
            GRANT: begin
                if (done || !req[gnt_id_q]) begin
                    state_d     = IDLE;
                    gnt_d       = 8'h00;
                    gnt_valid_d = 1'b0;
                    hold_d      = 8'd0;
                end else if (hold_q == HOLD_LIMIT) begin
                    state_d     = IDLE;
                    gnt_d       = 8'h00;
                    gnt_valid_d = 1'b0;
                    hold_d      = 8'd0;
                    timeout_d   = 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = 8'h00;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= 8'h00;
            gnt_id_q    <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_q      <= 8'd0;
            last_id_q   <= 3'd7;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_q      <= hold_d;
            last_id_q   <= last_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_round_robin_arbiter_8.sv
// Directed bench for round_robin_arbiter_8 built with MAX_HOLD=4; expected values are hand-computed.
module tb_round_robin_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int vectors;
    int miscompares;

    round_robin_arbiter_8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Compares all four outputs in one go.
    task automatic check_all(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_id,
                             input logic e_valid, input logic e_to);
        check({tag, ".gnt"}, gnt, e_gnt);
        check({tag, ".gnt_id"}, {5'd0, gnt_id}, {5'd0, e_id});
        check({tag, ".gnt_valid"}, {7'd0, gnt_valid}, {7'd0, e_valid});
        check({tag, ".timeout"}, {7'd0, timeout}, {7'd0, e_to});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        #2;
        check_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b1;

        // First grant goes to requester 0 (last_id=7 after reset).
        req = 8'b0000_1001;
        step();
        check_all("first_grant", 8'h01, 3'd0, 1'b1, 1'b0);

        // Release with done, one dead cycle, then requester 3.
        done = 1'b1;
        step();
        check_all("dead_cycle", 8'h00, 3'd0, 1'b0, 1'b0);
        done = 1'b0;
        step();
        check_all("second_grant", 8'h08, 3'd3, 1'b1, 1'b0);
        done = 1'b1;
        step();
        check_all("release_3", 8'h00, 3'd3, 1'b0, 1'b0);

        // done in IDLE with no requests is ignored.
        req = 8'h00;
        step();
        check_all("idle_done", 8'h00, 3'd3, 1'b0, 1'b0);
        done = 1'b0;
        step();
        check_all("idle_quiet", 8'h00, 3'd3, 1'b0, 1'b0);

        // Full rotation with wrap-around from a fresh reset.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step();
            check_all($sformatf("rotate_%0d", k), 8'h01 << (k % 8), 3'(k % 8), 1'b1, 1'b0);
            done = 1'b1;
            step();
            check_all($sformatf("rotate_gap_%0d", k), 8'h00, 3'(k % 8), 1'b0, 1'b0);
            done = 1'b0;
        end

        // Owner withdrawal ends the grant (last_id=0, so requester 2 wins).
        req = 8'h04;
        step();
        check_all("withdraw_grant", 8'h04, 3'd2, 1'b1, 1'b0);
        req = 8'h00;
        step();
        check_all("withdraw_release", 8'h00, 3'd2, 1'b0, 1'b0);

        // Hold limit: four grant cycles, timeout pulse in the IDLE cycle, then regrant.
        req = 8'h20;
        for (int c = 0; c < 4; c++) begin
            step();
            check_all($sformatf("hold_%0d", c), 8'h20, 3'd5, 1'b1, 1'b0);
        end
        step();
        check_all("timeout_pulse", 8'h00, 3'd5, 1'b0, 1'b1);
        step();
        check_all("regrant_5", 8'h20, 3'd5, 1'b1, 1'b0);

        // No preemption by other requesters; done at the limit wins over timeout.
        req = 8'hFF;
        step();
        check_all("no_preempt_1", 8'h20, 3'd5, 1'b1, 1'b0);
        step();
        check_all("no_preempt_2", 8'h20, 3'd5, 1'b1, 1'b0);
        step();
        check_all("at_limit", 8'h20, 3'd5, 1'b1, 1'b0);
        done = 1'b1;
        step();
        check_all("done_beats_limit", 8'h00, 3'd5, 1'b0, 1'b0);
        done = 1'b0;
        step();
        check_all("grant_6", 8'h40, 3'd6, 1'b1, 1'b0);

        // Asynchronous reset mid-grant drops everything without a clock edge.
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        req = 8'h80;
        step();
        check_all("after_reset_7", 8'h80, 3'd7, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/round_robin_arbiter_8.md
ROUND_ROBIN_ARBITER_8 -- requirements
Module: round_robin_arbiter_8

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, maximum number of cycles one grant may be held (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 The block SHALL have port req, input, 8, request lines; bit i = requester i.
REQ-005 The block SHALL have port done, input, 1, current owner releases the resource.
REQ-006 The block SHALL have port gnt, output, 8, one-hot grant vector, registered.
REQ-007 The block SHALL have port gnt_id, output, 3, binary index of granted requester (8:3 encoding of gnt), registered.
REQ-008 The block SHALL have port gnt_valid, output, 1, high while any grant is active.
REQ-009 The block SHALL have port timeout, output, 1, one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one owner).
REQ-011 In IDLE with req != 0 at a clock edge, the block SHALL enter GRANT at that edge, selecting the first set req bit searching upward from (last_id+1) mod 8 with wrap-around.
REQ-012 Grant latency SHALL be one cycle: req sampled at edge N, so gnt/gnt_id/gnt_valid are valid after edge N.
REQ-013 gnt SHALL be exactly one-hot in GRANT and 8'h00 in IDLE; gnt_id SHALL equal the encoded index of gnt in GRANT and hold its last value in IDLE.
REQ-014 last_id SHALL update to the new gnt_id on every entry to GRANT.
REQ-015 In GRANT, the block SHALL return to IDLE at the next edge when done=1, or when req[gnt_id]=0 (owner withdraws).
REQ-016 A hold counter SHALL clear on entry to GRANT and increment each GRANT cycle; when it equals MAX_HOLD-1 without a release, the block SHALL return to IDLE and assert timeout for exactly that one cycle.
REQ-017 If done/withdrawal and the MAX_HOLD limit coincide, release SHALL win and timeout SHALL stay 0.
REQ-018 Exit from GRANT SHALL always pass through IDLE for at least one cycle (one dead cycle between consecutive grants).
REQ-019 done asserted while in IDLE SHALL be ignored.
REQ-020 Requests from non-owners during GRANT SHALL be ignored until the next IDLE cycle; no preemption.
REQ-021 Each requester continuously requesting SHALL be granted at least once in every 8 consecutive grants (starvation-free).

Reset
REQ-022 On rst_n=0, asynchronously: state=IDLE, gnt=8'h00, gnt_id=3'd0, gnt_valid=0, timeout=0, hold counter=0, last_id=3'd7 (so requester 0 has first priority).
REQ-023 Reset asserted mid-grant SHALL drop the grant immediately, without a timeout pulse; after rst_n rises, arbitration SHALL resume from IDLE at the next edge.

Verification
REQ-024 After reset, req=8'b0000_1001 -> next cycle gnt=8'b0000_0001, gnt_id=0, gnt_valid=1.
REQ-025 From REQ-024, done=1 for one cycle with req unchanged -> one IDLE cycle (gnt=0), then gnt=8'b0000_1000, gnt_id=3.
REQ-026 last_id=7, req=8'hFF held, done pulsed each grant -> gnt_id sequence 0,1,2,...,7,0 (wrap-around).
REQ-027 MAX_HOLD=4, req=8'b0010_0000 held, done=0 -> gnt_id=5 for 4 cycles, then IDLE with timeout=1 for one cycle, regrant to 5 the following cycle.
REQ-028 done=1 on the same cycle the hold limit is reached -> return to IDLE, timeout=0.
REQ-029 rst_n pulled low while gnt=8'h40 -> gnt=0 and gnt_valid=0 without waiting for clk; after release, req=8'h80 -> gnt_id=7 one cycle later.
